// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and stage-boundary payload widths for pipe_stage_register
package pipe_pkg;

  // Occupancy of a pipeline stage register; PIPE_TWO only exists with the skid buffer
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

  // Packed payload widths per stage boundary
  // IF/ID : pc(32) + instr(32)
  localparam int IF_ID_W  = 64;
  // ID/EX : pc(32) + rs1_val(32) + rs2_val(32) + imm(32) + rd(5) + ctrl(16)
  localparam int ID_EX_W  = 149;
  // EX/MEM: alu_res(32) + rs2_val(32) + rd(5) + ctrl(8)
  localparam int EX_MEM_W = 77;
  // MEM/WB: result(32) + rd(5) + ctrl(4)
  localparam int MEM_WB_W = 41;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats increment; increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_register.sv
// rtl/pipe_stage_register.sv - valid/ready pipeline stage register with flush, stall counter and optional skid buffer (PIPE_STAGE_SKID_EN)
module pipe_stage_register
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
  parameter int                 STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  input  logic                   stall_cnt_clr_i
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid_o = (state_q != PIPE_EMPTY);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_ready_q;
  logic              in_ready_d;

  // Two-entry occupancy: a payload arriving while the output stalls parks in skid
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush_i) begin
      state_d = PIPE_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (in_fire) begin
            state_d = PIPE_ONE;
            main_d  = in_data_i;
          end
        end
        PIPE_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = PIPE_TWO;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = PIPE_EMPTY;
          end
        end
        PIPE_TWO: begin
          if (out_fire) begin
            state_d = PIPE_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = PIPE_EMPTY;
      endcase
    end
    // Ready is derived from next occupancy so it never sees out_ready_i combinationally
    in_ready_d = (state_d != PIPE_TWO);
  end

  // Occupancy, payload and ready registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PIPE_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o = in_ready_q;
`else
  // Single entry: accept whenever the held payload is absent or leaving this cycle
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = PIPE_EMPTY;
      main_d  = RESET_VAL;
    end else if (in_fire) begin
      state_d = PIPE_ONE;
      main_d  = in_data_i;
    end else if (out_fire) begin
      state_d = PIPE_EMPTY;
    end
  end

  // Occupancy and payload registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PIPE_EMPTY;
      main_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  assign in_ready_o = !out_valid_o | out_ready_i;
`endif

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (out_valid_o & ~out_ready_i),
    .clr     (stall_cnt_clr_i),
    .cnt     (stall_cnt_o)
  );

endmodule

// File: doc/pipe_stage_register.md
# pipe_stage_register

Parametrised pipeline stage register with valid/ready handshake, synchronous flush, an optional two-entry skid buffer and a saturating stall counter. Successor to the fixed-field inter-stage registers (IF/ID … MEM/WB). Any stage boundary of the RISC-V pipeline instantiates it with its fields packed into one `DATA_W` bus. Bubbles are real invalid slots, so the hazard unit stalls and flushes through the handshake instead of gating the clock or zeroing control bits.

## Interface
- `DATA_W`, 32: width of the packed payload.
- `RESET_VAL`, 0: payload value held after reset and after a flush (`DATA_W` bits).
- `STALL_CNT_W`, 16: stall counter width, at least 1.
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset. One clock domain.
- `flush_i` input 1: synchronous kill of all held entries.
- `in_valid_i` input 1: upstream has a payload.
- `in_ready_o` output 1: stage accepts a payload this cycle.
- `in_data_i` input `DATA_W`: upstream payload.
- `out_valid_o` output 1: output payload valid.
- `out_ready_i` input 1: downstream consumes this cycle.
- `out_data_o` output `DATA_W`: output payload, always driven from a register.
- `stall_cnt_o` output `STALL_CNT_W`: saturating count of stalled cycles.
- `stall_cnt_clr_i` input 1: synchronous clear of `stall_cnt_o`.

## Operation
- Handshake events:
  - `in_fire` = `in_valid_i & in_ready_o`.
  - `out_fire` = `out_valid_o & out_ready_i`.
- Handshake rules:
  - Payload transfers only on a fire.
  - Upstream holds `in_data_i` stable while `in_valid_i=1` and not fired.
  - `out_data_o` holds stable while `out_valid_o=1` and not fired.
- Skid mode has three states:
  - EMPTY: no entries.
  - ONE: main entry valid.
  - TWO: main and skid entries valid.
- Skid-mode transitions:
  - EMPTY, `in_fire` → ONE; main ← in.
  - ONE, `in_fire & out_fire` → ONE; main ← in.
  - ONE, `in_fire & !out_fire` → TWO; skid ← in.
  - ONE, `!in_fire & out_fire` → EMPTY.
  - TWO, `out_fire` → ONE; main ← skid. `in_fire` is impossible in TWO.
  - No event → state held.
- Skid-mode outputs:
  - `out_valid_o` = state != EMPTY.
  - `out_data_o` = main.
  - `in_ready_o` = state != TWO. It is a registered signal with no combinational path from `out_ready_i`.
- `flush_i` has highest priority:
  - Next state EMPTY.
  - main and skid ← `RESET_VAL`.
  - An `in_fire` in the same cycle is discarded. Upstream is flushed in the same cycle by the hazard unit.
  - An `out_fire` in the same cycle still counts downstream.
- Stall counter:
  - Increments when `out_valid_o & !out_ready_i` and it is below all-ones.
  - Saturates at all-ones.
  - `stall_cnt_clr_i` wins over increment; the counter becomes 0.
  - `flush_i` does not affect the counter.

## Timing
- Reset values (`reset_n=0`, applied asynchronously):
  - State EMPTY; `out_valid_o=0`; `in_ready_o=1`.
  - `out_data_o=RESET_VAL`; skid entry = `RESET_VAL`; `stall_cnt_o=0`.
- Latency: payload accepted at edge N appears on `out_data_o` after edge N, one cycle.
- Throughput: one payload per cycle while `out_ready_i=1`.
- Full condition: skid mode holds at most 2 payloads. `in_ready_o` falls the cycle after the TWO state is entered and rises the cycle after the first `out_fire` in TWO.
- Simultaneous `flush_i` with `stall_cnt_clr_i`: both take effect.
- Reset mid-transfer: all held payloads are lost. No fire is reported for them.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer as above; `in_ready_o` is registered.
- `PIPE_STAGE_SKID_EN` undefined: single entry; states are EMPTY and ONE only.
  - `in_ready_o` = `!out_valid_o | out_ready_i`, combinational.
  - Flush, stall counter, reset values and latency are unchanged.

## Structure
- Package `pipe_pkg` holds:
  - the state enum (`PIPE_EMPTY`, `PIPE_ONE`, `PIPE_TWO`), 2 bits;
  - the packed-field width constants for each stage boundary (`IF_ID_W`, `ID_EX_W`, `EX_MEM_W`, `MEM_WB_W`).
- One sub-module, `sat_counter`, implements the stall counter:
  - parameter `W`;
  - inputs `inc`, `clr`;
  - output `cnt`;
  - `clk`/`reset_n` as above.

## Test plan
- Reset, then `in_valid_i=1`, `in_data_i=0x0000_00AA`, `out_ready_i=1` → `out_valid_o=1`, `out_data_o=0xAA` one cycle later.
- Stream 0x1..0x8 back-to-back with `out_ready_i=1` → eight consecutive output cycles in order, no bubbles, `stall_cnt_o=0`.
- Skid build: send 0x11, 0x22, 0x33 with `out_ready_i=0` → 0x11 and 0x22 held, `in_ready_o=0`, 0x33 not accepted. Then set `out_ready_i=1` → outputs 0x11, 0x22, 0x33 in order. `stall_cnt_o` equals the number of stalled cycles.
- Flush in TWO state with `in_valid_i=1` → next cycle `out_valid_o=0`, `out_data_o=RESET_VAL`, `in_ready_o=1`, and the input payload does not appear.
- Stall counter with `STALL_CNT_W=3`: hold `out_ready_i=0` for 10 cycles → saturates at 7. Then `stall_cnt_clr_i` → 0.
- Assert `reset_n` low asynchronously mid-stream → `out_valid_o=0` immediately. After release, the first accepted payload passes through in one cycle.
